msg_buffer: RTL and testbench

Parametrised message buffer between the serial character receiver and the plot command parser. Synchronises the receiver's asynchronous `CHAR_READY` strobe into the system clock domain. Appends characters with an internal write pointer and closes the message on a terminator character. Exposes a registered random-access read port, plus length, full, overflow and end-of-message status.

---
 rtl/msg_buffer_pkg.sv | 27 ++
 rtl/edge_sync.sv | 37 +++
 rtl/msg_buffer.sv | 118 +++++++++++
 tb/tb_msg_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/msg_buffer_pkg.sv
// +-------------------------------------------------------------------------+
// | msg_buffer_pkg : shared types, constants and width helpers for msg_buffer |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package msg_buffer_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [7:0] BS_CHAR       = 8'h08;
  localparam logic [7:0] DEF_TERM_CHAR = 8'h00;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// +-------------------------------------------------------------------------+
// | edge_sync : two-flop synchroniser followed by a rising-edge detector     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Resetting to RESET_VAL=1 suppresses an edge for a level already high at release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= RESET_VAL;
      sync   <= RESET_VAL;
      sync_d <= RESET_VAL;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

`default_nettype wire

// File: rtl/msg_buffer.sv
// +-------------------------------------------------------------------------+
// | msg_buffer : character message buffer with terminator, random read port  |
// | Optional: MSG_BUFFER_BACKSPACE_EN makes 8'h08 delete the last character.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module msg_buffer
  import msg_buffer_pkg::*;
#(
  parameter int                 CHAR_W    = 8,
  parameter int                 DEPTH     = 100,
  parameter logic [CHAR_W-1:0]  TERM_CHAR = DEF_TERM_CHAR
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [CHAR_W-1:0]                next_character,
  input  logic                             CHAR_READY,
  input  logic                             clear,
  input  logic [idx_width(DEPTH)-1:0]      index,
  output logic [CHAR_W-1:0]                curr_character,
  output logic [len_width(DEPTH)-1:0]      length,
  output logic                             END_OF_BUFFER,
  output logic                             full,
  output logic                             overflow
);

  localparam int                IDX_W   = idx_width(DEPTH);
  localparam int                LEN_W   = len_width(DEPTH);
  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [LEN_W-1:0]    length_nxt;
  logic                eob_nxt;
  logic                ovf_nxt;
  logic                wr_en;
  logic                char_event;
  logic [CHAR_W-1:0]   mem [DEPTH];

  edge_sync #(
    .RESET_VAL (1'b1)
  ) u_edge_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (CHAR_READY),
    .pulse    (char_event)
  );

  assign full = (length == DEPTH_L);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FILL;
      length        <= '0;
      END_OF_BUFFER <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      length        <= length_nxt;
      END_OF_BUFFER <= eob_nxt;
      overflow      <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    length_nxt = length;
    eob_nxt    = END_OF_BUFFER;
    ovf_nxt    = overflow;
    wr_en      = 1'b0;
    // clear wins over a coincident character, which is simply dropped
    if (clear) begin
      state_nxt  = FILL;
      length_nxt = '0;
      eob_nxt    = 1'b0;
      ovf_nxt    = 1'b0;
    end else if (char_event && (state == FILL)) begin
      if (next_character == TERM_CHAR) begin
        state_nxt = DONE;
        eob_nxt   = 1'b1;
      end
`ifdef MSG_BUFFER_BACKSPACE_EN
      else if (next_character == CHAR_W'(BS_CHAR)) begin
        if (length != '0) begin
          length_nxt = length - LEN_W'(1);
        end
      end
`endif
      else if (!full) begin
        wr_en      = 1'b1;
        length_nxt = length + LEN_W'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[length[IDX_W-1:0]] <= next_character;
    end
  end

  // Gating by the pre-write length hides stale and same-cycle-written entries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      curr_character <= TERM_CHAR;
    end else if (LEN_W'(index) < length) begin
      curr_character <= mem[index];
    end else begin
      curr_character <= TERM_CHAR;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msg_buffer.sv
// +-------------------------------------------------------------------------+
// | tb_msg_buffer : directed + randomized self-checking bench for msg_buffer |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_msg_buffer;

  localparam int         DEPTH = 6;
  localparam logic [7:0] TERM  = 8'h00;

  logic       clock;
  logic       reset_n;
  logic [7:0] next_character;
  logic       CHAR_READY;
  logic       clear;
  logic [2:0] index;
  logic [7:0] curr_character;
  logic [2:0] length;
  logic       END_OF_BUFFER;
  logic       full;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: message contents as a queue plus two flags
  logic [7:0] q[$];
  bit         m_done;
  bit         m_ovf;

  msg_buffer #(
    .CHAR_W    (8),
    .DEPTH     (DEPTH),
    .TERM_CHAR (TERM)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .next_character (next_character),
    .CHAR_READY     (CHAR_READY),
    .clear          (clear),
    .index          (index),
    .curr_character (curr_character),
    .length         (length),
    .END_OF_BUFFER  (END_OF_BUFFER),
    .full           (full),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_char(input logic [7:0] c);
    if (m_done) return;
    if (c == TERM) begin
      m_done = 1'b1;
      return;
    end
`ifdef MSG_BUFFER_BACKSPACE_EN
    if (c == 8'h08) begin
      if (q.size() > 0) void'(q.pop_back());
      return;
    end
`endif
    if (q.size() < DEPTH) q.push_back(c);
    else m_ovf = 1'b1;
  endtask

  // Called at a negedge; clr_hit raises clear on the cycle the edge is taken
  task automatic send(input logic [7:0] c, input bit clr_hit);
    next_character = c;
    CHAR_READY     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      clear = clr_hit && (i == 1);
    end
    CHAR_READY = 1'b0;
    clear      = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clock);
    if (clr_hit) model_reset();
    else model_char(c);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    model_reset();
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".length"},   32'(length),        32'(q.size()));
    chk({tag, ".full"},     32'(full),          32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow),      32'(m_ovf));
    chk({tag, ".eob"},      32'(END_OF_BUFFER), 32'(m_done));
  endtask

  task automatic check_reads(input string tag);
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      index = 3'(i);
      @(negedge clock);
      exp = (i < q.size()) ? q[i] : TERM;
      chk($sformatf("%s.rd%0d", tag, i), 32'(curr_character), 32'(exp));
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    CHAR_READY     = 1'b0;
    clear          = 1'b0;
    index          = '0;
    next_character = '0;
    model_reset();
    #12;
    check_status("reset");
    chk("reset.curr", 32'(curr_character), 32'(TERM));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);

    // Basic message G,0,1,TERM
    send("G", 1'b0); check_status("g");
    send("0", 1'b0); check_status("g0");
    send("1", 1'b0); check_status("g01");
    send(TERM, 1'b0); check_status("term");
    check_reads("msg");

    // Ignored in DONE, then clear coincident with an event
    send("X", 1'b0); check_status("done_x");
    check_reads("done");
    send("X", 1'b1); check_status("clr_evt");
    check_reads("clr");

    // Fill past capacity
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(8'("a" + i), 1'b0);
      check_status($sformatf("fill%0d", i));
    end
    check_reads("full");

    // Backspace sequence, and backspace at empty
    do_clear();
    send(8'h08, 1'b0); check_status("bs_empty");
    send("A", 1'b0); send("B", 1'b0); send(8'h08, 1'b0); send("C", 1'b0);
    check_status("bs_seq");
    check_reads("bs");

    // CHAR_READY high through reset release
    CHAR_READY = 1'b1;
    reset_n    = 1'b0;
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clock);
    check_status("hi_rst");
    CHAR_READY = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clock);
    send("Q", 1'b0); check_status("hi_rst_one");
    check_reads("hi_rst");

    // Asynchronous reset mid-message
    do_clear();
    for (int i = 0; i < 5; i++) send(8'("k" + i), 1'b0);
    check_status("pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_status("mid_rst");
    chk("mid_rst.curr", 32'(curr_character), 32'(TERM));
    @(negedge clock);
    reset_n = 1'b1;
    index   = '0;
    @(negedge clock);
    chk("post_rst.rd0", 32'(curr_character), 32'(TERM));

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8 || (m_done && r < 40)) do_clear();
      else if (r < 16) send(TERM, 1'b0);
      else if (r < 26) send(8'h08, 1'b0);
      else if (r < 30) send(8'("A" + $urandom_range(0, 25)), 1'b1);
      else send(8'("A" + $urandom_range(0, 25)), 1'b0);
      check_status($sformatf("rnd%0d", it));
      if (it % 3 == 0) check_reads($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
